// File: rtl/router_out_fifo.sv
`timescale 1ns/1ps
// router_out_fifo: per-destination output buffer of the 1x3 router, storing {header flag, byte}.
// Optional macro ROUTER_OUT_FIFO_OCC_EN adds the occupancy and sticky overflow ports.
module router_out_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
`ifdef ROUTER_OUT_FIFO_OCC_EN
    output logic [AW:0]      occupancy,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] data_out
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-2:0] pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH:0]   rd_word;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign data_out = data_out_q;

    // Flags are sampled before the edge, so a full FIFO takes the read and drops the write.
    assign wr_fire = write_enb && !full && !soft_reset;
    assign rd_fire = read_enb && !empty && !soft_reset;
    assign rd_word = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pkt_cnt_d  = pkt_cnt_q;
        data_out_d = data_out_q;
        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pkt_cnt_d  = '0;
            data_out_d = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                data_out_d = rd_word[WIDTH-1:0];
                // Header: remaining reads = payload length plus the parity byte.
                if (rd_word[WIDTH]) begin
                    pkt_cnt_d = {1'b0, rd_word[WIDTH-1:2]} + 1'b1;
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - 1'b1;
                end
            end else if (pkt_cnt_q == '0) begin
                data_out_d = '0;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_cnt_q  <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pkt_cnt_q  <= pkt_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= {lfd_state, data_in};
        end
    end

`ifdef ROUTER_OUT_FIFO_OCC_EN
    logic overflow_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (soft_reset) begin
            overflow_q <= 1'b0;
        end else if (write_enb && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign occupancy = count_q;
    assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_router_out_fifo.sv
`timescale 1ns/1ps
// tb_router_out_fifo: directed stimulus with a read-data scoreboard for router_out_fifo.
module tb_router_out_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AW    = 4;

    logic             clock      = 1'b0;
    logic             resetn     = 1'b0;
    logic             soft_reset = 1'b0;
    logic             write_enb  = 1'b0;
    logic             read_enb   = 1'b0;
    logic             lfd_state  = 1'b0;
    logic [WIDTH-1:0] data_in    = '0;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;
`ifdef ROUTER_OUT_FIFO_OCC_EN
    logic [AW:0]      occupancy;
    logic             overflow;
`endif

    router_out_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
`ifdef ROUTER_OUT_FIFO_OCC_EN
        .occupancy  (occupancy),
        .overflow   (overflow),
`endif
        .data_out   (data_out)
    );

    // Clock / reset
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH:0]   mdl_q[$];
    logic             rd_expect = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: one clock of stimulus; the reference queue decides acceptance.
    task automatic cycle(input logic we, input logic re, input logic lfd, input logic [WIDTH-1:0] din);
        logic           wr_ok;
        logic           rd_ok;
        logic [WIDTH:0] w;
        wr_ok = we && (mdl_q.size() < DEPTH);
        rd_ok = re && (mdl_q.size() > 0);
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = din;
        rd_expect = rd_ok;
        if (rd_ok) begin
            w = mdl_q.pop_front();
            exp_q.push_back(w[WIDTH-1:0]);
        end
        if (wr_ok) mdl_q.push_back({lfd, din});
        @(posedge clock);
        #1;
        write_enb = 1'b0;
        read_enb  = 1'b0;
        rd_expect = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic sr_cycle(input logic we, input logic [WIDTH-1:0] din);
        soft_reset = 1'b1;
        write_enb  = we;
        data_in    = din;
        mdl_q.delete();
        @(posedge clock);
        #1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
    endtask

    // Monitor: a read accepted at an edge shows its byte on data_out after that edge.
    always begin : monitor
        logic pend;
        logic [WIDTH-1:0] e;
        @(posedge clock);
        pend = rd_expect;
        @(negedge clock);
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_data: got %0h with no expected byte queued", data_out);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", {24'h0, data_out}, {24'h0, e});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset / idle
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", data_out, 0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("rd_on_empty_dout", data_out, 0);
        check("rd_on_empty_empty", empty, 1);

        // Single packet: header 0x0D (payload 3), A1..A3, parity AF; pause mid-packet
        cycle(1'b1, 1'b0, 1'b1, 8'h0D);
        cycle(1'b1, 1'b0, 1'b0, 8'hA1);
        cycle(1'b1, 1'b0, 1'b0, 8'hA2);
        cycle(1'b1, 1'b0, 1'b0, 8'hA3);
        cycle(1'b1, 1'b0, 1'b0, 8'hAF);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, '0);
        idle();
        check("pkt_hold_midway", data_out, 8'hA1);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, '0);
        check("parity_visible", data_out, 8'hAF);
        idle();
        check("pkt_clear_dout", data_out, 0);
        check("pkt_clear_empty", empty, 1);

        // Full boundary: 17 writes, last one dropped
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 14) check("not_full_15", full, 0);
            if (i == 15) check("full_16", full, 1);
            if (i == 16) check("full_after_drop", full, 1);
        end
`ifdef ROUTER_OUT_FIFO_OCC_EN
        check("occ_full", occupancy, 16);
        check("overflow_set", overflow, 1);
`endif
        repeat (16) cycle(1'b0, 1'b1, 1'b0, '0);
        idle();
        check("drain_empty", empty, 1);
        check("drain_dout", data_out, 0);

        // Simultaneous read/write while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        check("refill_full", full, 1);
        cycle(1'b1, 1'b1, 1'b0, 8'h55);
        check("sim_full_full", full, 0);
        check("sim_full_empty", empty, 0);
`ifdef ROUTER_OUT_FIFO_OCC_EN
        check("sim_full_occ", occupancy, 15);
`endif
        repeat (15) cycle(1'b0, 1'b1, 1'b0, '0);
        idle();
        check("sim_full_drained", empty, 1);

        // Simultaneous read/write while empty
        cycle(1'b1, 1'b1, 1'b0, 8'h66);
        check("sim_empty_empty", empty, 0);
        check("sim_empty_dout", data_out, 0);
`ifdef ROUTER_OUT_FIFO_OCC_EN
        check("sim_empty_occ", occupancy, 1);
`endif
        cycle(1'b0, 1'b1, 1'b0, '0);
        idle();
        check("sim_empty_drained", empty, 1);

        // Wrap-around: 40 write/read pairs
        cycle(1'b1, 1'b0, 1'b0, 8'h80);
        for (int i = 1; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
        cycle(1'b0, 1'b1, 1'b0, '0);
        idle();
        check("wrap_empty", empty, 1);

        // Soft reset mid-packet
        cycle(1'b1, 1'b0, 1'b1, 8'h11);
        cycle(1'b1, 1'b0, 1'b0, 8'hB1);
        cycle(1'b1, 1'b0, 1'b0, 8'hB2);
        cycle(1'b1, 1'b0, 1'b0, 8'hB3);
        cycle(1'b1, 1'b0, 1'b0, 8'hB4);
        cycle(1'b1, 1'b0, 1'b0, 8'hBF);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, '0);
        check("pre_sr_dout", data_out, 8'hB1);
        sr_cycle(1'b1, 8'h77);
        check("sr_empty", empty, 1);
        check("sr_dout", data_out, 0);
        check("sr_full", full, 0);
`ifdef ROUTER_OUT_FIFO_OCC_EN
        check("sr_overflow_clr", overflow, 0);
`endif
        idle();
        check("sr_write_ignored", empty, 1);

        // Async reset mid-cycle
        cycle(1'b1, 1'b0, 1'b1, 8'h09);
        cycle(1'b1, 1'b0, 1'b0, 8'hC1);
        cycle(1'b0, 1'b1, 1'b0, '0);
        idle();
        check("hold_before_arst", data_out, 8'h09);
        #2 resetn = 1'b0;
        mdl_q.delete();
        #1;
        check("arst_empty", empty, 1);
        check("arst_dout", data_out, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 8'hD5);
        cycle(1'b0, 1'b1, 1'b0, '0);
        idle();
        check("pkt_cnt_cleared_by_arst", data_out, 0);

        repeat (2) idle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_out_fifo.md
Name: router_out_fifo

Overview:
- Per-destination output buffer fed directly by the router register stage.
- Stores 9-bit words: a header flag (lfd_state) plus a data byte.
- Presents bytes to the destination reader one cycle after each read request.
- Tracks packet length from the header so that stale output is cleared once a packet has been fully drained.
- Three instances sit in the 1x3 router, one per output port.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
WIDTH, 8, data byte width (the stored word is WIDTH+1 bits)
AW, $clog2(DEPTH), pointer width; derived, not overridden

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
soft_reset  input  1  synchronous flush (reader timeout); active high
write_enb  input  1  write request from the router FSM/sync
read_enb  input  1  read request from the destination
lfd_state  input  1  header flag stored as bit WIDTH of the word
data_in  input  WIDTH  byte from the router register stage
full  output  1  count == DEPTH
empty  output  1  count == 0
data_out  output  WIDTH  registered read data

Behaviour:
- Reset and flush: on resetn low, asynchronously clear wr_ptr, rd_ptr, count (AW+1 bits), pkt_cnt (WIDTH-1 bits) and data_out to 0. Memory contents are not cleared.
- Soft reset: soft_reset high at a clock edge applies the same clear synchronously and overrides any read/write in that cycle.
- Status flags: full and empty are combinational decodes of count. After reset: empty=1, full=0, data_out=0.
- Write: accepted when write_enb && !full. mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr increments modulo DEPTH. A write while full is dropped silently, with no pointer change.
- Read: accepted when read_enb && !empty. data_out <= mem[rd_ptr][WIDTH-1:0] at that edge (1-cycle latency); rd_ptr increments modulo DEPTH. A read while empty is ignored.
- Simultaneous events:
  - Read and write both accepted in one cycle: count unchanged.
  - When full: the read is accepted and the write is dropped (full is sampled before the edge).
  - When empty: the write is accepted and the read is ignored.
- Packet counter (pkt_cnt), updated on each accepted read:
  - If the read word's flag bit is 1 (header): pkt_cnt <= data[WIDTH-1:2] + 1, i.e. payload length plus parity byte.
  - Otherwise, if pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
- Output clear: on any edge with no accepted read and pkt_cnt == 0, data_out <= 0. data_out otherwise holds its last value.
- Consequence of the output clear: the parity byte stays visible until the next edge, then clears to 0 if no new read occurs.
- Header with payload length 0: pkt_cnt loads 1; the next read (parity) brings it to 0.

Optional Feature:
- Macro: ROUTER_OUT_FIFO_OCC_EN.
- Defined:
  - Adds output port occupancy [AW:0] equal to count.
  - Adds output port overflow (1 bit), a sticky flag set when write_enb && full.
  - overflow is cleared by resetn or soft_reset.
- Undefined: neither port exists and no overflow logic is built; all other behaviour is identical.

Test Plan:
- Reset/idle: resetn low 3 cycles, then high -> empty=1, full=0, data_out=8'h00; read_enb=1 on empty -> data_out stays 8'h00.
- Single packet drain: write {1,8'h0D} (payload 3), then 8'hA1, 8'hA2, 8'hA3, parity 8'hAF. Read 5 back-to-back -> data_out = 0D, A1, A2, A3, AF on the cycles after each read. One idle cycle later data_out=8'h00, empty=1.
- Full boundary: write 17 bytes 8'h00..8'h10 with DEPTH=16 -> full=1 after the 16th write and 8'h10 is dropped. Read all 16 -> 8'h00..8'h0F in order, then empty=1.
- Simultaneous read/write: with full=1, assert write_enb and read_enb together -> count stays 16-1=15 and full deasserts. With empty=1, do the same -> count=1 and data_out unchanged.
- Wrap-around: run 40 write/read pairs with incrementing data -> read sequence matches the write sequence, exercising pointer wrap.
- Soft reset mid-packet: write 6 words, read 2, pulse soft_reset with write_enb=1 -> next cycle empty=1, data_out=8'h00, and the write is ignored. Async resetn pulsed mid-cycle -> outputs clear immediately.
